// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared CPU-wide types and constants for the fetch front end:
//               address width, reset PC, PC increment and the fetch packet.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int CPU_ADDR_W = 32;

  localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = '0;

  // One ARM instruction word per fetch
  localparam logic [CPU_ADDR_W-1:0] PC_INC = CPU_ADDR_W'(4);

  // A fetched word together with the address it was fetched from
  typedef struct packed {
    logic [31:0]           instr;
    logic [CPU_ADDR_W-1:0] pc;
  } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry synchronous FIFO of fetch packets with push, pop
//               and a flush that empties the queue in one cycle. Head data is
//               read straight from the storage array (registered state only).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_pkt_t       push_data_i,
  input  logic             pop_i,
  output fetch_pkt_t       head_o,
  output logic [PTR_W:0]   count_o,
  output logic             empty_o
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  fetch_pkt_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic w_pop;
  logic w_push;

  // A pop needs data; a push into a full queue is only legal alongside a pop
  assign w_pop  = pop_i && (count_q != '0);
  assign w_push = push_i && ((count_q != DEPTH_CNT) || w_pop);

  // Pointer and occupancy bookkeeping; flush discards everything at once
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_stage
// Description : ARM instruction-fetch stage. Owns the PC, drives a
//               synchronous-read instruction memory (data one cycle after the
//               request), buffers words in a prefetch queue and presents
//               {instr, pc} to decode over valid/ready. Redirects flush the
//               queue and squash the response arriving in the same cycle.
//               Optional macro FETCH_ALIGN_CHECK_EN: a misaligned redirect
//               target raises a sticky fetch_fault and halts fetching.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_stage
  import cpu_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                IMEM_AW  = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_plus8,
  output logic               fetch_fault
);

  localparam int             PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q,       pc_d;
  logic [ADDR_W-1:0] req_pc_q,   req_pc_d;
  logic              inflight_q, inflight_d;

  logic [ADDR_W-1:0] w_redir_pc;
  logic              w_halt;
  logic              w_issue;
  logic              w_push;
  logic [PTR_W:0]    w_count;
  logic [PTR_W:0]    w_occupancy;
  fetch_pkt_t        w_push_pkt;
  fetch_pkt_t        w_head;
  logic              w_empty;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign w_redir_pc  = redirect_pc;
  assign w_halt      = fault_q;
  assign fetch_fault = fault_q;

  // Fault is sticky: set by any redirect to a non-word-aligned target
  always_comb begin
    fault_d = fault_q;
    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) fault_d = 1'b1;
  end

  // Fault flag register, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
`else
  // Low address bits of a redirect carry no meaning for word fetch
  assign w_redir_pc  = redirect_pc & ~ADDR_W'(3);
  assign w_halt      = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Queued words plus the one possibly in flight must fit in the queue
  assign w_occupancy = w_count + (PTR_W+1)'(inflight_q);
  assign w_issue     = !reset && !redirect_valid && !w_halt && (w_occupancy < DEPTH_CNT);

  // A response arriving in a redirect cycle belongs to the old path
  assign w_push     = inflight_q && !redirect_valid;
  assign w_push_pkt = '{instr: imem_rdata, pc: CPU_ADDR_W'(req_pc_q)};

  assign imem_req  = w_issue;
  assign imem_addr = pc_q[IMEM_AW+1:2];

  // Next PC: redirect beats sequential advance; request PC latched on issue
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = w_issue;
    if (redirect_valid) begin
      pc_d = w_redir_pc;
    end else if (w_issue) begin
      pc_d     = pc_q + ADDR_W'(PC_INC);
      req_pc_d = pc_q;
    end
  end

  // PC, in-flight flag and request-address registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (w_push),
    .push_data_i (w_push_pkt),
    .pop_i       (out_ready),
    .head_o      (w_head),
    .count_o     (w_count),
    .empty_o     (w_empty)
  );

  assign out_valid    = !w_empty;
  assign out_instr    = w_head.instr;
  assign out_pc       = ADDR_W'(w_head.pc);
  assign out_pc_plus8 = out_pc + ADDR_W'(8);

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue_stage
// Description : Self-checking bench for fetch_queue_stage. A queue-based
//               model tracks which words must be visible to decode; every
//               cycle the DUT outputs are compared to it, and directed
//               literal checks pin the key latencies and sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_stage;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 32;
  localparam int IMEM_AW = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata = '0;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [ADDR_W-1:0]  out_pc_plus8;
  logic               fetch_fault;

  fetch_queue_stage #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .IMEM_AW  (IMEM_AW),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus8   (out_pc_plus8),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: word i holds E3A0_0000 + i
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= 32'hE3A0_0000 + {22'b0, imem_addr};
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } pkt_t;

  pkt_t        mq[$];
  bit          pend_v;
  pkt_t        pend;
  logic [31:0] m_pc;
  bit          m_fault;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'hE3A0_0000 + {22'b0, pc[11:2]};
  endfunction

  function automatic bit m_req();
    return !reset && !redirect_valid && !m_fault && ((mq.size() + int'(pend_v)) < DEPTH);
  endfunction

  task automatic compare_cycle();
    chk("model_out_valid", out_valid, (mq.size() != 0));
    if (mq.size() != 0) begin
      chk("model_out_pc", out_pc, mq[0].pc);
      chk("model_out_instr", out_instr, mq[0].instr);
      chk("model_out_pc_plus8", out_pc_plus8, mq[0].pc + 32'd8);
    end
    chk("model_imem_req", imem_req, m_req());
    if (m_req()) chk("model_imem_addr", imem_addr, m_pc[11:2]);
    chk("model_fetch_fault", fetch_fault, m_fault);
  endtask

  task automatic model_step();
    bit req;
    req = m_req();
    if (reset) begin
      mq.delete();
      pend_v  = 0;
      m_pc    = 32'h0;
      m_fault = 0;
    end else if (redirect_valid) begin
      mq.delete();
      pend_v = 0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) m_fault = 1;
`endif
      m_pc = redirect_pc & ~32'd3;
    end else begin
      if (out_ready && mq.size() != 0) void'(mq.pop_front());
      if (pend_v) mq.push_back(pend);
      pend_v = req;
      if (req) begin
        pend.pc    = m_pc;
        pend.instr = word_at(m_pc);
        m_pc       = m_pc + 32'd4;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    m_pc           = 32'h0;
    m_fault        = 0;
    pend_v         = 0;
    repeat (2) @(posedge clk);
    #1;
    ticks(2);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_imem_req", imem_req, 0);
    chk("reset_fetch_fault", fetch_fault, 0);

    // Streaming with decode always ready
    reset = 1'b0; out_ready = 1'b1; #1;
    chk("first_imem_req", imem_req, 1);
    chk("first_imem_addr", imem_addr, 0);
    chk("first_out_valid", out_valid, 0);
    ticks(2);
    chk("stream_valid_c2", out_valid, 1);
    chk("stream_pc_c2", out_pc, 32'h0);
    chk("stream_instr_c2", out_instr, 32'hE3A0_0000);
    chk("stream_plus8_c2", out_pc_plus8, 32'h8);
    ticks(8);
    chk("stream_pc_c10", out_pc, 32'h20);
    chk("stream_instr_c10", out_instr, 32'hE3A0_0008);

    // Redirect with two queued words and one in flight
    out_ready = 1'b0;
    ticks(1);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    ticks(1);
    redirect_valid = 1'b0; #1;
    chk("redir_valid_r1", out_valid, 0);
    chk("redir_req_r1", imem_req, 1);
    chk("redir_addr_r1", imem_addr, 10'h40);
    ticks(1);
    chk("redir_valid_r2", out_valid, 0);
    ticks(1);
    chk("redir_valid_r3", out_valid, 1);
    chk("redir_pc_r3", out_pc, 32'h100);
    chk("redir_instr_r3", out_instr, 32'hE3A0_0040);

    // Redirect coinciding with pop and push while queue+inflight is full
    ticks(2);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    ticks(1);
    redirect_valid = 1'b0; #1;
    chk("flush_valid_r1", out_valid, 0);
    ticks(2);
    chk("flush_pc_r3", out_pc, 32'h200);
    chk("flush_instr_r3", out_instr, 32'hE3A0_0080);

    // Mid-stream reset, then stall until the queue fills
    ticks(4);
    reset = 1'b1; out_ready = 1'b0;
    ticks(1);
    reset = 1'b0; #1;
    chk("mid_reset_valid", out_valid, 0);
    chk("mid_reset_req", imem_req, 1);
    chk("mid_reset_addr", imem_addr, 0);
    ticks(10);
    chk("stall_req", imem_req, 0);
    chk("stall_valid", out_valid, 1);
    chk("stall_pc", out_pc, 32'h0);
    chk("stall_instr", out_instr, 32'hE3A0_0000);
    out_ready = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_pc", out_pc, 64'(k * 4));
      ticks(1);
    end

    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    ticks(1);
    redirect_valid = 1'b0; #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("align_fault_set", fetch_fault, 1);
    chk("align_req_off", imem_req, 0);
    ticks(5);
    chk("align_fault_sticky", fetch_fault, 1);
    chk("align_req_stays_off", imem_req, 0);
    chk("align_valid_off", out_valid, 0);
    reset = 1'b1;
    ticks(1);
    reset = 1'b0; #1;
    chk("align_fault_cleared", fetch_fault, 0);
    chk("align_req_restart", imem_req, 1);
`else
    chk("align_no_fault", fetch_fault, 0);
    chk("align_req_on", imem_req, 1);
    chk("align_addr_masked", imem_addr, 10'h40);
    ticks(2);
    chk("align_pc_masked", out_pc, 32'h100);
`endif
    ticks(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
